conv_rd_ctrl: RTL and testbench

- Read-side stage feeding the convolution controller and the convolution datapath.
- On each start address from the controller, streams one image/filter block from memory through a small credit-limited FIFO to the conv unit.
- Reports the current pixel row/column and signals the end of the block with its last address.

---
 rtl/conv_rd_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_conv_rd_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_rd_ctrl.sv
// conv_rd_ctrl: read-side stage for the convolution unit. Streams one
// image/filter block per start address from memory through a credit-limited
// return FIFO, tracks the pixel row/column being delivered and flags job end.
module conv_rd_ctrl #(
  parameter int unsigned word_len     = 32,
  parameter int unsigned channel_size = 64,
  parameter int unsigned img_dim      = 64,
  parameter int unsigned fifo_depth   = 4,
  parameter int unsigned addr_step    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                conv_start,
  input  logic                CcCrb_initAddrEn,
  input  logic [27:0]         CcCrb_initAddr,
  output logic                mem_rdReq,
  output logic [27:0]         mem_rdAddr,
  input  logic                mem_rdGnt,
  input  logic                mem_rdValid,
  input  logic [word_len-1:0] mem_rdData,
  output logic                pix_valid,
  output logic [word_len-1:0] pix_data,
  input  logic                pix_ready,
  output logic                CrbCc_imgEnd,
  output logic [27:0]         CrbCc_imgEndAddr,
  output logic [5:0]          ptr,
  output logic [5:0]          ptc,
  output logic                pt_en
);

  localparam int unsigned N     = img_dim * img_dim * channel_size;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned OUT_W = $clog2(fifo_depth + 1);
  localparam int unsigned PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int unsigned CH_W  = (channel_size > 1) ? $clog2(channel_size) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic [27:0]         base;
  logic [CNT_W-1:0]    issued, consumed;
  logic [OUT_W-1:0]    outstanding, out_nxt, stale, occupancy;
  logic [OUT_W:0]      in_flight;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [word_len-1:0] fifo_mem [fifo_depth];
  logic [CH_W-1:0]     chan;
  logic [5:0]          row, col;
  logic                start, credit_ok, gnt_fire, ret_fire, push, pop;
  logic                last_issue, last_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(fifo_depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake decode; returns are discarded while stale (pre-abort) reads drain.
  always_comb begin
    start        = (state == IDLE) && CcCrb_initAddrEn && conv_start;
    in_flight    = {1'b0, outstanding} + {1'b0, occupancy};
    credit_ok    = in_flight < (OUT_W + 1)'(fifo_depth);
    mem_rdReq    = conv_start && (state == ISSUE) && (stale == '0) && credit_ok;
    mem_rdAddr   = base + 28'(issued * addr_step);
    gnt_fire     = mem_rdReq && mem_rdGnt;
    ret_fire     = mem_rdValid && (outstanding != '0);
    push         = ret_fire && conv_start && (stale == '0);
    pix_valid    = (occupancy != '0);
    pix_data     = fifo_mem[rd_ptr];
    pop          = pix_valid && pix_ready && conv_start;
    last_issue   = gnt_fire && (issued == CNT_W'(N - 1));
    last_pop     = pop && (consumed == CNT_W'(N - 1));
    CrbCc_imgEnd = (state == DONE);
    out_nxt      = outstanding + OUT_W'(gnt_fire) - OUT_W'(ret_fire);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; DONE is entered on the edge of the final pop so the
  // end pulse lands exactly one cycle after it.
  always_comb begin
    state_nxt = state;
    if (!conv_start) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (CcCrb_initAddrEn) state_nxt = ISSUE;
        ISSUE: if (last_issue)       state_nxt = DRAIN;
        DRAIN: if (last_pop)         state_nxt = DONE;
        DONE:                        state_nxt = IDLE;
        default:                     state_nxt = IDLE;
      endcase
    end
  end

  // Job bookkeeping: base address, issue/consume counters, end address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base             <= '0;
      issued           <= '0;
      consumed         <= '0;
      CrbCc_imgEndAddr <= '0;
    end else if (!conv_start) begin
      issued   <= '0;
      consumed <= '0;
    end else begin
      if (start) begin
        base     <= CcCrb_initAddr;
        issued   <= '0;
        consumed <= '0;
      end
      if (gnt_fire) issued <= issued + 1'b1;
      if (last_issue) CrbCc_imgEndAddr <= mem_rdAddr;
      if (pop) consumed <= consumed + 1'b1;
    end
  end

  // Outstanding-read count and the number of those that belong to an aborted job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      stale       <= '0;
    end else begin
      outstanding <= out_nxt;
      if (!conv_start)                 stale <= out_nxt;
      else if (ret_fire && stale != '0) stale <= stale - 1'b1;
    end
  end

  // Return-data FIFO; flushed whenever the job is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      for (int unsigned i = 0; i < fifo_depth; i++) fifo_mem[PTR_W'(i)] <= '0;
    end else if (!conv_start) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= mem_rdData;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      occupancy <= occupancy + 1'b1;
      else if (pop && !push) occupancy <= occupancy - 1'b1;
    end
  end

  // Pixel tracking: publish row/column on the first channel word of each pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan  <= '0;
      row   <= '0;
      col   <= '0;
      ptr   <= '0;
      ptc   <= '0;
      pt_en <= 1'b0;
    end else begin
      pt_en <= 1'b0;
      if (!conv_start) begin
        chan <= '0;
        row  <= '0;
        col  <= '0;
        ptr  <= '0;
        ptc  <= '0;
      end else if (start) begin
        chan <= '0;
        row  <= '0;
        col  <= '0;
      end else if (pop) begin
        if (chan == '0) begin
          ptr   <= row;
          ptc   <= col;
          pt_en <= 1'b1;
        end
        if (chan == CH_W'(channel_size - 1)) begin
          chan <= '0;
          if (col == 6'(img_dim - 1)) begin
            col <= '0;
            row <= (row == 6'(img_dim - 1)) ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end else begin
          chan <= chan + 1'b1;
        end
      end
    end
  end

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && occupancy == OUT_W'(fifo_depth)));

endmodule

// File: tb/tb_conv_rd_ctrl.sv
// Directed bench for conv_rd_ctrl with a 2-cycle-latency memory responder.
module tb_conv_rd_ctrl;
  localparam int unsigned WL    = 32;
  localparam int unsigned CH    = 2;
  localparam int unsigned DIM   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NW    = DIM * DIM * CH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          conv_start = 1'b0;
  logic          CcCrb_initAddrEn = 1'b0;
  logic [27:0]   CcCrb_initAddr = '0;
  logic          mem_rdReq;
  logic [27:0]   mem_rdAddr;
  logic          mem_rdGnt = 1'b0;
  logic          mem_rdValid;
  logic [WL-1:0] mem_rdData;
  logic          pix_valid;
  logic [WL-1:0] pix_data;
  logic          pix_ready = 1'b0;
  logic          CrbCc_imgEnd;
  logic [27:0]   CrbCc_imgEndAddr;
  logic [5:0]    ptr, ptc;
  logic          pt_en;

  always #5 clk = ~clk;

  conv_rd_ctrl #(
    .word_len(WL), .channel_size(CH), .img_dim(DIM), .fifo_depth(DEPTH), .addr_step(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .conv_start(conv_start),
    .CcCrb_initAddrEn(CcCrb_initAddrEn), .CcCrb_initAddr(CcCrb_initAddr),
    .mem_rdReq(mem_rdReq), .mem_rdAddr(mem_rdAddr), .mem_rdGnt(mem_rdGnt),
    .mem_rdValid(mem_rdValid), .mem_rdData(mem_rdData),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .CrbCc_imgEnd(CrbCc_imgEnd), .CrbCc_imgEndAddr(CrbCc_imgEndAddr),
    .ptr(ptr), .ptc(ptc), .pt_en(pt_en)
  );

  // Memory: data = {4'h5, addr}, returned 2 cycles after the grant edge.
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [27:0] a1 = '0, a2 = '0;
  always @(posedge clk) begin
    v1 <= mem_rdReq && mem_rdGnt;
    a1 <= mem_rdAddr;
    v2 <= v1;
    a2 <= a1;
  end
  assign mem_rdValid = v2;
  assign mem_rdData  = {4'h5, a2};

  // Event log sampled mid-cycle.
  logic [27:0]   iss_q[$];
  logic [WL-1:0] pop_q[$];
  logic [11:0]   pt_q[$];
  int neg_cyc = 0, end_cnt = 0, end_cyc = 0, last_pop_cyc = 0;
  always @(negedge clk) begin
    neg_cyc++;
    if (mem_rdReq && mem_rdGnt) iss_q.push_back(mem_rdAddr);
    if (pix_valid && pix_ready) begin
      pop_q.push_back(pix_data);
      last_pop_cyc = neg_cyc;
    end
    if (pt_en) pt_q.push_back({ptr, ptc});
    if (CrbCc_imgEnd) begin
      end_cnt++;
      end_cyc = neg_cyc;
    end
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_job(input logic [27:0] a);
    conv_start       = 1'b1;
    CcCrb_initAddr   = a;
    CcCrb_initAddrEn = 1'b1;
    cycles(1);
    CcCrb_initAddrEn = 1'b0;
  endtask

  task automatic wait_end(input int target, input string tag);
    int n = 0;
    while (end_cnt < target && n < 200) begin
      cycles(1);
      n++;
    end
    check(tag, 64'(end_cnt >= target), 64'd1);
  endtask

  // Checks that a whole job from base a was issued and delivered in order.
  task automatic check_job(input string t, input logic [27:0] a, input int ib, input int pb);
    check({t, "_n_issued"}, 64'(iss_q.size() - ib), 64'(NW));
    check({t, "_n_popped"}, 64'(pop_q.size() - pb), 64'(NW));
    for (int i = 0; i < int'(NW); i++) begin
      check($sformatf("%s_addr%0d", t, i), 64'(iss_q[ib + i]), 64'(a + 28'(i)));
      check($sformatf("%s_data%0d", t, i), 64'(pop_q[pb + i]), 64'({4'h5, a + 28'(i)}));
    end
    check({t, "_endaddr"}, 64'(CrbCc_imgEndAddr), 64'(a + 28'(NW - 1)));
  endtask

  initial begin
    int ib, pb, tb0, eb;
    logic [11:0] exp_pt [4];
    exp_pt[0] = {6'd0, 6'd0};
    exp_pt[1] = {6'd0, 6'd1};
    exp_pt[2] = {6'd1, 6'd0};
    exp_pt[3] = {6'd1, 6'd1};

    #12;
    check("reset_outs_a", 64'({mem_rdReq, mem_rdAddr, pix_valid, CrbCc_imgEnd, pt_en}), 64'd0);
    check("reset_outs_b", 64'({CrbCc_imgEndAddr, ptr, ptc}), 64'd0);
    check("reset_pix_data", 64'(pix_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(1);

    // T1: free-running grant, pix_ready high.
    mem_rdGnt = 1'b1; pix_ready = 1'b1;
    ib = iss_q.size(); pb = pop_q.size(); tb0 = pt_q.size(); eb = end_cnt;
    start_job(28'h100);
    wait_end(eb + 1, "t1_end_seen");
    cycles(3);
    check_job("t1", 28'h100, ib, pb);
    check("t1_end_once", 64'(end_cnt - eb), 64'd1);
    check("t1_end_latency", 64'(end_cyc - last_pop_cyc), 64'd1);
    check("t1_n_pt", 64'(pt_q.size() - tb0), 64'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_pt%0d", i), 64'(pt_q[tb0 + i]), 64'(exp_pt[i]));

    // T2: consumer stalled; credit caps outstanding work at the FIFO depth.
    pix_ready = 1'b0;
    ib = iss_q.size(); pb = pop_q.size(); eb = end_cnt;
    start_job(28'h100);
    cycles(12);
    check("t2_stall_issued", 64'(iss_q.size() - ib), 64'd4);
    check("t2_stall_req", 64'(mem_rdReq), 64'd0);
    check("t2_stall_valid", 64'(pix_valid), 64'd1);
    pix_ready = 1'b1;
    cycles(1);
    pix_ready = 1'b0;
    cycles(6);
    check("t2_one_pop_one_req", 64'(iss_q.size() - ib), 64'd5);
    pix_ready = 1'b1;
    wait_end(eb + 1, "t2_end_seen");
    cycles(3);
    check_job("t2", 28'h100, ib, pb);

    // T3: grant withheld; request and address must hold.
    mem_rdGnt = 1'b0;
    ib = iss_q.size(); pb = pop_q.size(); eb = end_cnt;
    start_job(28'h100);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_req_hold%0d", i), 64'(mem_rdReq), 64'd1);
      check($sformatf("t3_addr_hold%0d", i), 64'(mem_rdAddr), 64'h100);
      cycles(1);
    end
    mem_rdGnt = 1'b1;
    wait_end(eb + 1, "t3_end_seen");
    cycles(3);
    check_job("t3", 28'h100, ib, pb);

    // T4: filter region.
    ib = iss_q.size(); pb = pop_q.size(); eb = end_cnt;
    start_job(28'h800_0000);
    wait_end(eb + 1, "t4_end_seen");
    cycles(3);
    check_job("t4", 28'h800_0000, ib, pb);
    check("t4_bit27", 64'(CrbCc_imgEndAddr[27]), 64'd1);

    // T5: second start mid-ISSUE is ignored.
    ib = iss_q.size(); pb = pop_q.size(); eb = end_cnt;
    start_job(28'h100);
    cycles(2);
    CcCrb_initAddr = 28'h200; CcCrb_initAddrEn = 1'b1;
    cycles(1);
    CcCrb_initAddrEn = 1'b0;
    wait_end(eb + 1, "t5_end_seen");
    cycles(5);
    check_job("t5", 28'h100, ib, pb);
    check("t5_no_second_job", 64'(iss_q.size() - ib), 64'(NW));

    // T6: abort with two reads outstanding and two words queued.
    pix_ready = 1'b0;
    ib = iss_q.size(); eb = end_cnt;
    start_job(28'h100);
    cycles(4);
    check("t6_issued_before_abort", 64'(iss_q.size() - ib), 64'd4);
    conv_start = 1'b0;
    cycles(1);
    check("t6_fifo_flushed", 64'(pix_valid), 64'd0);
    pb = pop_q.size();
    pix_ready = 1'b1;
    cycles(5);
    check("t6_late_dropped", 64'(pix_valid), 64'd0);
    check("t6_no_pop", 64'(pop_q.size() - pb), 64'd0);
    check("t6_no_end", 64'(end_cnt - eb), 64'd0);
    check("t6_ptr_ptc_zero", 64'({ptr, ptc}), 64'd0);
    ib = iss_q.size(); pb = pop_q.size();
    start_job(28'h300);
    wait_end(eb + 1, "t6_end_seen");
    cycles(3);
    check_job("t6", 28'h300, ib, pb);

    // T7: asynchronous reset mid-DRAIN, one return still in flight.
    ib = iss_q.size(); eb = end_cnt;
    start_job(28'h100);
    cycles(9);
    check("t7_in_drain_req", 64'(mem_rdReq), 64'd0);
    check("t7_in_drain_issued", 64'(iss_q.size() - ib), 64'(NW));
    rst_n = 1'b0;
    #1;
    check("t7_rst_outs_a", 64'({mem_rdReq, mem_rdAddr, pix_valid, CrbCc_imgEnd, pt_en}), 64'd0);
    check("t7_rst_outs_b", 64'({CrbCc_imgEndAddr, ptr, ptc}), 64'd0);
    #1;
    rst_n = 1'b1;
    pb = pop_q.size();
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      check($sformatf("t7_late_ignored%0d", i), 64'({pix_valid, mem_rdReq}), 64'd0);
    end
    check("t7_no_end", 64'(end_cnt - eb), 64'd0);
    check("t7_no_pop", 64'(pop_q.size() - pb), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
